// File: rtl/gpu_pkg.sv
// Shared definitions for the SIMD unit blocks.
//
// Holds the fetch FSM state encoding (also exported on the fetcher's
// fetch_state port, so the numeric values are part of the interface) and
// the default program memory address / instruction word widths.
package gpu_pkg;

    localparam int DEFAULT_PROGRAM_MEM_ADDR_WIDTH = 32;
    localparam int DEFAULT_INSTR_WIDTH            = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCHING   = 2'd1,
        FETCHED    = 2'd2,
        DRAIN      = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetcher.sv
// Per-SIMD instruction fetch stage.
//
// Latches the wave's program counter, runs one valid/ready read against
// program memory, holds the returned instruction for decode and pulses
// UPDATE_PC back to the PC block once decode has consumed it. At most one
// fetch is ever outstanding.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   enable                    gates new fetch starts and hand-off to decode
//   FETCH_START               scheduler requests a fetch of pc_in
//   DISPATCH_NEW_WAVE         abort whatever fetch is in progress
//   pc_in                     current program counter from PC
//   mem_read_valid/address    read request to program memory
//   mem_read_ready/data       memory response
//   instr_out, INSTR_VALID    held instruction for decode
//   DECODE_ACK                decode consumes instr_out
//   UPDATE_PC                 one-cycle pulse telling PC to advance
//   fetch_state               current FSM state
module instr_fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_WIDTH = DEFAULT_PROGRAM_MEM_ADDR_WIDTH,
    parameter int INSTR_WIDTH            = DEFAULT_INSTR_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              FETCH_START,
    input  logic                              DISPATCH_NEW_WAVE,
    input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_in,
    output logic                              mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] mem_read_address,
    input  logic                              mem_read_ready,
    input  logic [INSTR_WIDTH-1:0]            mem_read_data,
    output logic [INSTR_WIDTH-1:0]            instr_out,
    output logic                              INSTR_VALID,
    input  logic                              DECODE_ACK,
    output logic                              UPDATE_PC,
    output logic [1:0]                        fetch_state
);

    fetch_state_t state;

    assign fetch_state = state;

    // Single FSM with all outputs registered. A new fetch is refused while
    // UPDATE_PC is high: PC has not yet advanced, so pc_in would be stale.
    // Aborts never retract an issued request; a pending read is drained and
    // its data thrown away so the memory handshake stays consistent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= FETCH_IDLE;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instr_out        <= '0;
            INSTR_VALID      <= 1'b0;
            UPDATE_PC        <= 1'b0;
        end else begin
            UPDATE_PC <= 1'b0;
            case (state)
                FETCH_IDLE: begin
                    if (!DISPATCH_NEW_WAVE && enable && FETCH_START && !UPDATE_PC) begin
                        mem_read_address <= pc_in;
                        mem_read_valid   <= 1'b1;
                        state            <= FETCHING;
                    end
                end
                FETCHING: begin
                    if (DISPATCH_NEW_WAVE) begin
                        if (mem_read_ready) begin
                            mem_read_valid <= 1'b0;
                            state          <= FETCH_IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (mem_read_ready) begin
                        instr_out      <= mem_read_data;
                        INSTR_VALID    <= 1'b1;
                        mem_read_valid <= 1'b0;
                        state          <= FETCHED;
                    end
                end
                FETCHED: begin
                    if (DISPATCH_NEW_WAVE) begin
                        INSTR_VALID <= 1'b0;
                        state       <= FETCH_IDLE;
                    end else if (enable && DECODE_ACK) begin
                        INSTR_VALID <= 1'b0;
                        UPDATE_PC   <= 1'b1;
                        state       <= FETCH_IDLE;
                    end
                end
                DRAIN: begin
                    if (mem_read_ready) begin
                        mem_read_valid <= 1'b0;
                        state          <= FETCH_IDLE;
                    end
                end
                default: begin
                    state          <= FETCH_IDLE;
                    mem_read_valid <= 1'b0;
                    INSTR_VALID    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed bench for instr_fetcher. Inputs are driven 1 time unit after a
// rising edge and outputs are checked at that same point, i.e. they show
// the state produced by the edge just taken. Instructions returned by the
// memory model for non-aborted fetches are queued and popped when
// INSTR_VALID is seen.
module tb_instr_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fetch_start;
    logic        dispatch;
    logic [31:0] pc_in;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        decode_ack;
    logic        update_pc;
    logic [1:0]  fetch_state;

    int          total = 0;
    int          bad = 0;
    logic [31:0] expected_q[$];
    logic [31:0] held;

    instr_fetcher #(
        .PROGRAM_MEM_ADDR_WIDTH(32),
        .INSTR_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .FETCH_START(fetch_start),
        .DISPATCH_NEW_WAVE(dispatch),
        .pc_in(pc_in),
        .mem_read_valid(mem_valid),
        .mem_read_address(mem_addr),
        .mem_read_ready(mem_ready),
        .mem_read_data(mem_data),
        .instr_out(instr_out),
        .INSTR_VALID(instr_valid),
        .DECODE_ACK(decode_ack),
        .UPDATE_PC(update_pc),
        .fetch_state(fetch_state)
    );

    always #5 clk = ~clk;

    // Hard stop in case something upstream of the bench wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fs, input logic dnw, input logic rdy,
                                 input logic [31:0] data, input logic ack);
        fetch_start = fs;
        dispatch    = dnw;
        mem_ready   = rdy;
        mem_data    = data;
        decode_ack  = ack;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Pops the scoreboard when an instruction is presented to decode.
    task automatic checkDelivered(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        if (expected_q.size() == 0) begin
            checkOutput({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            checkOutput({tag, "_instr"}, instr_out, expected_q.pop_front());
        end
    endtask

    task automatic checkIdleQuiet(input string tag);
        checkOutput({tag, "_state"}, {30'd0, fetch_state}, 32'd0);
        checkOutput({tag, "_rvalid"}, {31'd0, mem_valid}, 32'd0);
        checkOutput({tag, "_ivalid"}, {31'd0, instr_valid}, 32'd0);
        checkOutput({tag, "_upc"}, {31'd0, update_pc}, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        pc_in  = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        #12;
        checkIdleQuiet("reset");
        checkOutput("reset_addr", mem_addr, 32'd0);
        checkOutput("reset_instr", instr_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic fetch
        $display("[TB] basic fetch");
        pc_in = 32'd5;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("basic_state", {30'd0, fetch_state}, 32'd1);
        checkOutput("basic_rvalid", {31'd0, mem_valid}, 32'd1);
        checkOutput("basic_addr", mem_addr, 32'd5);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0);
        expected_q.push_back(32'hA5A5_0001);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkDelivered("basic");
        checkOutput("basic_rvalid_low", {31'd0, mem_valid}, 32'd0);
        checkOutput("basic_upc_early", {31'd0, update_pc}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();
        // Fetch requested while UPDATE_PC is high must be held off one cycle.
        pc_in = 32'd9;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("basic_upc", {31'd0, update_pc}, 32'd1);
        checkOutput("basic_ivalid_low", {31'd0, instr_valid}, 32'd0);
        checkOutput("basic_idle", {30'd0, fetch_state}, 32'd0);
        tick();
        checkIdleQuiet("early_start_blocked");

        // Memory stall: the held start is now accepted
        $display("[TB] memory stall");
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        pc_in = 32'd77;
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_state", {30'd0, fetch_state}, 32'd1);
            checkOutput("stall_rvalid", {31'd0, mem_valid}, 32'd1);
            checkOutput("stall_addr", mem_addr, 32'd9);
            checkOutput("stall_ivalid", {31'd0, instr_valid}, 32'd0);
            enable = (i != 2);
            tick();
        end
        enable = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        expected_q.push_back(32'h1234_5678);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        checkDelivered("stall");

        // Decode backpressure, including an ack masked by enable
        $display("[TB] decode backpressure");
        held = instr_out;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                enable     = 1'b0;
                decode_ack = 1'b1;
            end else begin
                enable     = 1'b1;
                decode_ack = 1'b0;
            end
            mem_ready = 1'b1;
            tick();
            checkOutput("bp_instr", instr_out, held);
            checkOutput("bp_ivalid", {31'd0, instr_valid}, 32'd1);
            checkOutput("bp_upc", {31'd0, update_pc}, 32'd0);
            checkOutput("bp_state", {30'd0, fetch_state}, 32'd2);
        end
        enable = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("bp_upc_pulse", {31'd0, update_pc}, 32'd1);
        tick();
        checkIdleQuiet("bp_after");

        // Abort mid-fetch
        $display("[TB] abort mid-fetch");
        pc_in = 32'd12;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("abort_fetching", {30'd0, fetch_state}, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("abort_drain", {30'd0, fetch_state}, 32'd3);
        checkOutput("abort_drain_rvalid", {31'd0, mem_valid}, 32'd1);
        tick();
        checkOutput("abort_drain2", {30'd0, fetch_state}, 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkIdleQuiet("abort_done");
        tick();
        checkIdleQuiet("abort_settled");

        // FETCH_START together with DISPATCH_NEW_WAVE in IDLE
        $display("[TB] simultaneous events");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkIdleQuiet("start_vs_dispatch");

        // Ready together with DISPATCH_NEW_WAVE while fetching
        pc_in = 32'd20;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hBAD0_0001, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkIdleQuiet("ready_vs_dispatch");

        // DECODE_ACK together with DISPATCH_NEW_WAVE in FETCHED
        pc_in = 32'd30;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0BAD_CAFE, 1'b0);
        expected_q.push_back(32'h0BAD_CAFE);
        tick();
        checkDelivered("ack_vs_dispatch_pre");
        checkOutput("ack_vs_dispatch_addr", mem_addr, 32'd30);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkIdleQuiet("ack_vs_dispatch");
        tick();
        checkOutput("ack_vs_dispatch_upc", {31'd0, update_pc}, 32'd0);

        // Asynchronous reset between edges
        $display("[TB] async reset");
        pc_in = 32'd40;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("areset_pre", {30'd0, fetch_state}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("areset_rvalid", {31'd0, mem_valid}, 32'd0);
        checkOutput("areset_state", {30'd0, fetch_state}, 32'd0);
        checkOutput("areset_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkIdleQuiet("areset_after");

        checkOutput("scoreboard_empty", expected_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
